led_sequencer: RTL and testbench
================================

# led_sequencer

Drives the four active-low board LEDs from a per-LED mode table written over a valid/ready config port, replacing free-running counter bits on the pins. One shared prescaler generates a global tick. Each LED runs its own small pattern engine: off, on, slow blink, fast blink, repeating N-pulse code, or one-shot N-pulse burst with a busy flag. The block sits between the fabric status/control logic and the `leds` pins.

## Interface
- `NUM_LEDS`, 4: number of LED channels; `cfg_led` width is fixed at 2, so the maximum is 4.
- `PRESCALE_WIDTH`, 20: prescaler width; one tick every 2^PRESCALE_WIDTH clocks.
- `clk`, in, 1: single clock.
- `rstn`, in, 1: reset, synchronous and active-low.
- `cfg_valid`, in, 1: config write request.
- `cfg_ready`, out, 1: block can accept a write.
- `cfg_led`, in, 2: target LED index.
- `cfg_mode`, in, 3: 0 OFF, 1 ON, 2 BLINK_SLOW, 3 BLINK_FAST, 4 PULSE_N, 5 ONESHOT; 6 and 7 behave as OFF.
- `cfg_count`, in, 4: pulse count N for modes 4 and 5.
- `leds`, out, NUM_LEDS: registered, active-low; 0 means lit.
- `busy`, out, NUM_LEDS: channel is executing a ONESHOT burst.

## Operation
- **Prescaler**
  - Free-running `PRESCALE_WIDTH`-bit up-counter that wraps.
  - `tick` is high for one cycle when the counter equals all-ones.
  - Config writes never touch the prescaler.
- **Handshake**
  - A write is accepted on an edge where `cfg_valid && cfg_ready`.
  - `cfg_ready` goes low for exactly the one cycle after each accept, then returns high.
  - Writes are never queued. The master holds `cfg_valid` and the data stable until accepted.
  - Writes with `cfg_led >= NUM_LEDS` are accepted and discarded.
- **Write restart**
  - An accepted write restarts the target channel: mode latched, phase counter cleared, pulse counter loaded with N.
  - Initial state by mode:
    - OFF and reserved modes: IDLE, dark.
    - ON, BLINK_SLOW, BLINK_FAST: LIT.
    - PULSE_N with N=0: IDLE, dark (constant).
    - ONESHOT with N=0: completes immediately, IDLE, busy=0.
    - Otherwise: LIT.
- **Channel FSM** (states IDLE, LIT, DARK, GAP); all state advances happen only on `tick`.
  - ON: stays LIT.
  - BLINK_SLOW: toggles LIT/DARK every 8 ticks (period 16 ticks).
  - BLINK_FAST: toggles every tick.
  - PULSE_N: LIT 1 tick, DARK 1 tick, repeated N times. Then GAP, dark, for 8 ticks, then reload N and return to LIT.
  - ONESHOT: same N pulses with no gap, then IDLE, dark. `busy` is high from restart until entry into IDLE.
- **Precedence**
  - A write and a tick on the same channel in the same cycle: the write wins and the tick is ignored for that channel.
  - A write to a busy ONESHOT channel preempts it. `busy` follows the new mode.
- **Reset**, applied on any cycle including mid-burst:
  - `leds` = all ones (dark), `busy` = 0, `cfg_ready` = 0.
  - Prescaler = 0, all modes OFF, all FSMs IDLE.
  - `cfg_ready` rises on the first edge after `rstn` is high.

## Timing
- Write accepted at edge E: channel registers load at E; `leds` reflects the new mode after edge E+1 (2-cycle latency from presentation).
- `busy` updates at E, together with the channel registers.
- Tick-driven transitions: the channel changes at tick edge T; `leds` follows at T+1.
- After reset release, the first tick occurs 2^PRESCALE_WIDTH − 1 cycles after the first non-reset edge.
- Tick phase is global, so the first LIT interval after a restart lasts 1 to 2^PRESCALE_WIDTH cycles. This is intended.
- Counter widths:
  - Phase counter is 3 bits (counts to 8).
  - Pulse counter is 4 bits (down-counts from N to 0).
  - No overflow is possible.

## Structure
- Shared package `led_seq_pkg` holds:
  - mode encodings MODE_OFF..MODE_ONESHOT;
  - FSM state encodings;
  - SLOW_TOGGLE_TICKS = 8 and GAP_TICKS = 8.
- Sub-module `led_channel`:
  - one FSM, phase counter, pulse counter and mode register;
  - inputs: `clk`, `rstn`, `tick`, `load`, `mode`, `count`;
  - outputs: `lit`, `busy`;
  - instantiated NUM_LEDS times.
- Top level holds the prescaler, handshake, write decode and the output register `leds = ~lit`.

## Test plan
All scenarios use PRESCALE_WIDTH=3 (tick every 8 cycles).
- Hold reset 5 cycles, then release → `leds`=4'b1111, `busy`=0 throughout reset; `cfg_ready`=0 during reset, 1 from the first edge after release.
- Write LED0 ON → `leds[0]`=0 two cycles after accept; `cfg_ready` low exactly 1 cycle; back-to-back `cfg_valid` accepted every 2nd cycle.
- Write LED3 BLINK_FAST, then LED2 BLINK_SLOW → LED3 toggles every 8 cycles; LED2 toggles every 64 cycles; both aligned to ticks.
- Write LED1 PULSE_N with N=3 → on/off pattern per tick: 1,0,1,0,1,0, then 8 dark ticks, then repeats.
- Write LED0 ONESHOT with N=2 → `busy[0]`=1 for 4 ticks, then 0 with LED dark. Rewrite mid-burst with ON → `busy[0]` drops at accept and LED is lit. N=0 → `busy` never rises.
- Assert reset mid-PULSE_N; issue a write coincident with a tick; write to `cfg_led`=3 with NUM_LEDS=3 → reset returns all dark/OFF; write wins over tick; out-of-range write is accepted and has no effect.

Source files
------------

// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
//
// Shared definitions for the LED sequencer: mode encodings written over the
// config port, channel FSM state encodings, tick-count constants and the
// restart decode used when a channel is (re)loaded.
// ---------------------------------------------------------------------------
package led_seq_pkg;

    typedef logic [2:0] mode_t;
    typedef logic [1:0] state_t;

    // Config mode encodings; 6 and 7 are reserved and behave as OFF.
    localparam mode_t MODE_OFF        = 3'd0;
    localparam mode_t MODE_ON         = 3'd1;
    localparam mode_t MODE_BLINK_SLOW = 3'd2;
    localparam mode_t MODE_BLINK_FAST = 3'd3;
    localparam mode_t MODE_PULSE_N    = 3'd4;
    localparam mode_t MODE_ONESHOT    = 3'd5;

    // Channel FSM states.
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LIT  = 2'd1;
    localparam state_t ST_DARK = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    localparam int unsigned SLOW_TOGGLE_TICKS = 8;
    localparam int unsigned GAP_TICKS         = 8;

    // Last phase value before a transition; the phase counter is 3 bits wide.
    localparam logic [2:0] SLOW_LAST = 3'(SLOW_TOGGLE_TICKS - 1);
    localparam logic [2:0] GAP_LAST  = 3'(GAP_TICKS - 1);

    // State a channel enters when a write restarts it.
    function automatic state_t restart_state(mode_t mode, logic [3:0] count);
        case (mode)
            MODE_ON, MODE_BLINK_SLOW, MODE_BLINK_FAST: return ST_LIT;
            // A zero-length pulse code is a constant dark output, and a
            // zero-length burst completes immediately.
            MODE_PULSE_N, MODE_ONESHOT: return (count != 4'd0) ? ST_LIT : ST_IDLE;
            default: return ST_IDLE;
        endcase
    endfunction

    // busy is raised only by a burst that actually has pulses to emit.
    function automatic logic restart_busy(mode_t mode, logic [3:0] count);
        return (mode == MODE_ONESHOT) && (count != 4'd0);
    endfunction

endpackage

// File: rtl/led_channel.sv
// ---------------------------------------------------------------------------
// led_channel
//
// One LED pattern engine. Holds the mode register, the stored pulse count,
// the FSM, a 3-bit phase counter and a 4-bit pulse down-counter. All pattern
// progress happens on the shared tick; a load restarts the channel and takes
// priority over a coincident tick.
//
// Ports:
//   clk    in   clock
//   rstn   in   synchronous active-low reset
//   tick   in   global prescaler tick, one cycle wide
//   load   in   restart this channel with mode/count
//   mode   in   mode to latch on load
//   count  in   pulse count N to latch on load
//   lit    out  channel currently wants its LED lit (combinational from state)
//   busy   out  channel is executing a ONESHOT burst (registered)
// ---------------------------------------------------------------------------
module led_channel
    import led_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick,
    input  logic       load,
    input  logic [2:0] mode,
    input  logic [3:0] count,
    output logic       lit,
    output logic       busy
);

    state_t     state_q, state_d;
    mode_t      mode_q,  mode_d;
    logic [2:0] phase_q, phase_d;
    logic [3:0] pulse_q, pulse_d;
    logic [3:0] n_q,     n_d;
    logic       busy_q,  busy_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        phase_d = phase_q;
        pulse_d = pulse_q;
        n_d     = n_q;
        busy_d  = busy_q;

        if (load) begin
            mode_d  = mode;
            n_d     = count;
            pulse_d = count;
            phase_d = 3'd0;
            state_d = restart_state(mode, count);
            busy_d  = restart_busy(mode, count);
        end else if (tick) begin
            case (state_q)
                ST_LIT: begin
                    case (mode_q)
                        MODE_ON: ;
                        MODE_BLINK_SLOW: begin
                            if (phase_q == SLOW_LAST) begin
                                state_d = ST_DARK;
                                phase_d = 3'd0;
                            end else begin
                                phase_d = phase_q + 3'd1;
                            end
                        end
                        MODE_BLINK_FAST: state_d = ST_DARK;
                        // The pulse is counted off as it ends.
                        MODE_PULSE_N, MODE_ONESHOT: begin
                            state_d = ST_DARK;
                            pulse_d = pulse_q - 4'd1;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
                ST_DARK: begin
                    case (mode_q)
                        MODE_BLINK_SLOW: begin
                            if (phase_q == SLOW_LAST) begin
                                state_d = ST_LIT;
                                phase_d = 3'd0;
                            end else begin
                                phase_d = phase_q + 3'd1;
                            end
                        end
                        MODE_BLINK_FAST: state_d = ST_LIT;
                        MODE_PULSE_N: begin
                            if (pulse_q != 4'd0) begin
                                state_d = ST_LIT;
                            end else begin
                                state_d = ST_GAP;
                                phase_d = 3'd0;
                            end
                        end
                        MODE_ONESHOT: begin
                            if (pulse_q != 4'd0) begin
                                state_d = ST_LIT;
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
                ST_GAP: begin
                    if (phase_q == GAP_LAST) begin
                        state_d = ST_LIT;
                        pulse_d = n_q;
                        phase_d = 3'd0;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_OFF;
            phase_q <= 3'd0;
            pulse_q <= 4'd0;
            n_q     <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            pulse_q <= pulse_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
        end
    end

    assign lit  = (state_q == ST_LIT);
    assign busy = busy_q;

endmodule

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
//
// Drives the active-low board LEDs from a per-LED mode table written over a
// valid/ready config port. A shared free-running prescaler produces the
// global tick that paces every channel's pattern engine.
//
// Ports:
//   clk        in   clock
//   rstn       in   synchronous active-low reset
//   cfg_valid  in   config write request
//   cfg_ready  out  block can accept a write (low for one cycle after accept)
//   cfg_led    in   target LED index; indices >= NUM_LEDS are discarded
//   cfg_mode   in   mode (see led_seq_pkg)
//   cfg_count  in   pulse count N for PULSE_N / ONESHOT
//   leds       out  registered LED pins, active-low (0 = lit)
//   busy       out  per-channel ONESHOT-in-progress flags
// ---------------------------------------------------------------------------
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 4,
    parameter int unsigned PRESCALE_WIDTH = 20
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_led,
    input  logic [2:0]          cfg_mode,
    input  logic [3:0]          cfg_count,
    output logic [NUM_LEDS-1:0] leds,
    output logic [NUM_LEDS-1:0] busy
);

    localparam logic [PRESCALE_WIDTH-1:0] PrescOne = PRESCALE_WIDTH'(1);

    // Prescaler: free-running and untouched by config traffic.
    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic                      tick;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PrescOne;
        end
    end

    assign tick = &presc_q;

    // Handshake: ready drops for the single cycle after every accept, which
    // paces a master holding valid high to one write every other cycle.
    logic ready_q;
    logic accept;

    assign accept = cfg_valid & ready_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ~accept;
        end
    end

    assign cfg_ready = ready_q;

    // Write decode and channels. Out-of-range indices match no channel, so
    // such writes complete the handshake and are dropped.
    logic [NUM_LEDS-1:0] load;
    logic [NUM_LEDS-1:0] lit;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        localparam logic [1:0] LedIdx = 2'(i);

        assign load[i] = accept && (cfg_led == LedIdx);

        led_channel u_chan (
            .clk   (clk),
            .rstn  (rstn),
            .tick  (tick),
            .load  (load[i]),
            .mode  (cfg_mode),
            .count (cfg_count),
            .lit   (lit[i]),
            .busy  (busy[i])
        );
    end

    // Output register; pins are active-low.
    logic [NUM_LEDS-1:0] leds_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            leds_q <= '1;
        end else begin
            leds_q <= ~lit;
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

    localparam int PW     = 3;
    localparam int PERIOD = 1 << PW;

    logic       clk       = 1'b0;
    logic       rstn      = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_led   = 2'd0;
    logic [2:0] cfg_mode  = 3'd0;
    logic [3:0] cfg_count = 4'd0;

    logic       cfg_ready;
    logic [3:0] leds;
    logic [3:0] busy;
    logic       cfg_ready3;
    logic [2:0] leds3;
    logic [2:0] busy3;

    led_sequencer #(
        .NUM_LEDS       (4),
        .PRESCALE_WIDTH (PW)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_led   (cfg_led),
        .cfg_mode  (cfg_mode),
        .cfg_count (cfg_count),
        .leds      (leds),
        .busy      (busy)
    );

    // Three-LED instance sharing the same stimulus: writes to index 3 must
    // be accepted and dropped, leaving channels 0..2 identical to u_dut.
    led_sequencer #(
        .NUM_LEDS       (3),
        .PRESCALE_WIDTH (PW)
    ) u_dut3 (
        .clk       (clk),
        .rstn      (rstn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready3),
        .cfg_led   (cfg_led),
        .cfg_mode  (cfg_mode),
        .cfg_count (cfg_count),
        .leds      (leds3),
        .busy      (busy3)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 50)
                $display("FAIL %s at %0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: each channel is described by its mode, N and the
    // number of ticks seen since its last restart; outputs follow from
    // plain arithmetic on that tick count.
    int       m_cnt = 0;
    bit       m_ready = 1'b0;
    bit       m_accept = 1'b0;
    bit [3:0] m_leds = 4'hf;
    int       m_mode[4];
    int       m_n[4];
    int       m_k[4];

    function automatic bit exp_lit(input int mode, input int n, input int k);
        int r;
        case (mode)
            1: return 1'b1;
            2: return ((k / 8) % 2) == 0;
            3: return (k % 2) == 0;
            4: begin
                if (n == 0) return 1'b0;
                r = k % (2 * n + 8);
                return (r < 2 * n) && (r % 2 == 0);
            end
            5: return (k < 2 * n) && (k % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_busy(input int mode, input int n, input int k);
        return (mode == 5) && (k < 2 * n);
    endfunction

    task automatic model_edge();
        bit tick;
        if (!rstn) begin
            m_cnt    = 0;
            m_ready  = 1'b0;
            m_accept = 1'b0;
            m_leds   = 4'hf;
            for (int i = 0; i < 4; i++) begin
                m_mode[i] = 0;
                m_n[i]    = 0;
                m_k[i]    = 0;
            end
        end else begin
            tick     = (m_cnt == PERIOD - 1);
            m_accept = cfg_valid && m_ready;
            for (int i = 0; i < 4; i++) m_leds[i] = !exp_lit(m_mode[i], m_n[i], m_k[i]);
            for (int i = 0; i < 4; i++) begin
                if (m_accept && int'(cfg_led) == i) begin
                    m_mode[i] = int'(cfg_mode);
                    m_n[i]    = int'(cfg_count);
                    m_k[i]    = 0;
                end else if (tick) begin
                    m_k[i]++;
                end
            end
            m_cnt   = (m_cnt + 1) % PERIOD;
            m_ready = !m_accept;
        end
    endtask

    task automatic compare_all();
        bit [3:0] eb;
        for (int i = 0; i < 4; i++) eb[i] = exp_busy(m_mode[i], m_n[i], m_k[i]);
        check_eq("leds", {28'd0, leds}, {28'd0, m_leds});
        check_eq("busy", {28'd0, busy}, {28'd0, eb});
        check_eq("cfg_ready", {31'd0, cfg_ready}, {31'd0, m_ready});
        check_eq("leds_n3", {29'd0, leds3}, {29'd0, m_leds[2:0]});
        check_eq("busy_n3", {29'd0, busy3}, {29'd0, eb[2:0]});
        check_eq("cfg_ready_n3", {31'd0, cfg_ready3}, {31'd0, m_ready});
    endtask

    // One clock: model and DUT advance on the same edge, outputs are
    // compared shortly after it, inputs change on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_req(input int led, input int mode, input int cnt);
        bit done;
        done      = 1'b0;
        cfg_led   = 2'(led);
        cfg_mode  = 3'(mode);
        cfg_count = 4'(cnt);
        cfg_valid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            step();
            done = m_accept;
        end
        if (!done) check_eq("write_timeout", 32'd0, 32'd1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int t;

        // Reset held for five edges.
        rstn = 1'b0;
        idle(5);
        check_eq("rst_leds", {28'd0, leds}, 32'hf);
        check_eq("rst_ready", {31'd0, cfg_ready}, 32'd0);
        rstn = 1'b1;
        step();
        check_eq("ready_after_release", {31'd0, cfg_ready}, 32'd1);

        // LED0 ON: ready low for one cycle, LED lit one edge after accept.
        write_req(0, 1, 0);
        check_eq("ready_low_after_accept", {31'd0, cfg_ready}, 32'd0);
        step();
        check_eq("led0_on", {31'd0, leds[0]}, 32'd0);
        check_eq("ready_back_high", {31'd0, cfg_ready}, 32'd1);

        // Valid held high: accepts land every other cycle.
        acc       = 0;
        cfg_led   = 2'd0;
        cfg_mode  = 3'd1;
        cfg_count = 4'd0;
        cfg_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (cfg_ready) acc++;
            step();
        end
        cfg_valid = 1'b0;
        check_eq("b2b_accepts", acc, 32'd3);

        // Blinkers.
        write_req(3, 3, 0);
        write_req(2, 2, 0);
        idle(150);

        // Pulse code N=3 over more than two periods.
        write_req(1, 4, 3);
        idle(8 * 30);

        // One-shot N=2 runs to completion.
        write_req(0, 5, 2);
        check_eq("oneshot_busy_rise", {31'd0, busy[0]}, 32'd1);
        idle(50);
        check_eq("oneshot_done", {31'd0, busy[0]}, 32'd0);

        // One-shot preempted by ON.
        write_req(0, 5, 2);
        idle(12);
        write_req(0, 1, 0);
        check_eq("preempt_busy", {31'd0, busy[0]}, 32'd0);
        step();
        check_eq("preempt_lit", {31'd0, leds[0]}, 32'd0);

        // Zero-length burst never raises busy.
        write_req(0, 5, 0);
        check_eq("n0_busy", {31'd0, busy[0]}, 32'd0);
        idle(20);

        // Reset in the middle of a pulse code.
        write_req(1, 4, 3);
        idle(20);
        rstn = 1'b0;
        idle(3);
        check_eq("midrst_leds", {28'd0, leds}, 32'hf);
        check_eq("midrst_busy", {28'd0, busy}, 32'd0);
        rstn = 1'b1;
        idle(20);

        // Write landing on a tick edge: the restart wins, so FAST stays lit
        // for a full tick period instead of toggling immediately.
        t = 0;
        while (!(m_cnt == PERIOD - 1 && m_ready) && t < 40) begin
            step();
            t++;
        end
        if (t >= 40) check_eq("tick_align_timeout", 32'd0, 32'd1);
        write_req(2, 3, 0);
        check_eq("tick_write_cnt", m_cnt, 32'd0);
        step();
        check_eq("tick_write_lit", {31'd0, leds[2]}, 32'd0);
        idle(PERIOD - 1);
        check_eq("tick_write_still_lit", {31'd0, leds[2]}, 32'd0);
        idle(PERIOD);

        // Out-of-range for the three-LED instance.
        write_req(3, 1, 0);
        check_eq("oor_ready_n3", {31'd0, cfg_ready3}, 32'd0);
        idle(4);

        // Randomized traffic with occasional resets.
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                rstn = 1'b0;
                idle(int'($urandom_range(1, 4)));
                rstn = 1'b1;
                step();
            end else begin
                write_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 15)));
                idle(int'($urandom_range(0, 60)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
